// File: rtl/pipeline_interlock_ctrl.sv
// Hazard/sequencing controller: forwarding selects, load/branch interlocks, redirect flush, memory-wait freeze.
// Latency: hazard outputs are combinational (zero cycle); FSM, wait counter, timeout flag and stall counter are registered.
// Backpressure: freeze holds the whole pipeline while data memory has not acked; interlocks hold PC and IF/ID and bubble ID/EX.
module pipeline_interlock_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic [1:0]       pcsource,
    input  logic [4:0]       ex_rn,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       mem_rn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             id_bubble,
    output logic             if_flush,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       ld_stall, br_stall;

    // Operand source for one register: EX ALU result beats MEM, r0 never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic [4:0] e_rn, input logic e_w, input logic e_ld,
                                           input logic [4:0] m_rn, input logic m_w, input logic m_ld);
        logic [1:0] sel;
        sel = 2'b00;
        if (r != 5'd0) begin
            if (e_w && !e_ld && e_rn == r)
                sel = 2'b01;
            else if (m_w && m_rn == r)
                sel = m_ld ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    // Memory-wait FSM state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Next state and freeze: an ack in the request cycle never freezes.
    always_comb begin
        state_nxt = state;
        freeze    = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_nxt = MWAIT;
                    freeze    = 1'b1;
                end
            end
            MWAIT: begin
                if (mem_ack)
                    state_nxt = RUN;
                else
                    freeze = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Wait counter counts frozen cycles (including the request cycle), saturating at MAX_WAIT.
    always_comb begin
        wait_nxt = 8'd0;
        if (freeze)
            wait_nxt = (wait_cnt == MAX_W) ? MAX_W : wait_cnt + 8'd1;
    end

    // Wait counter, sticky timeout and saturating stall counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wait_cnt     <= 8'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            wait_cnt <= wait_nxt;
            if (freeze && wait_nxt == MAX_W)
                mem_timeout <= 1'b1;
            if (!wpcir && stall_cycles != {CNT_W{1'b1}})
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // Forwarding selects and interlock detection.
    always_comb begin
        fwda     = fwd_sel(id_rs, ex_rn, ex_wreg, ex_m2reg, mem_rn, mem_wreg, mem_m2reg);
        fwdb     = fwd_sel(id_rt, ex_rn, ex_wreg, ex_m2reg, mem_rn, mem_wreg, mem_m2reg);
        ld_stall = ex_wreg && ex_m2reg && (ex_rn != 5'd0) &&
                   ((id_use_rs && ex_rn == id_rs) || (id_use_rt && ex_rn == id_rt));
        // The ID branch comparator reads the regfile/forward paths, which cannot carry EX results.
        br_stall = id_branch && ex_wreg && (ex_rn != 5'd0) &&
                   (ex_rn == id_rs || ex_rn == id_rt);
    end

    // Pipeline control priority: freeze, then interlock bubble, then redirect flush.
    always_comb begin
        wpcir     = 1'b1;
        id_bubble = 1'b0;
        if_flush  = 1'b0;
        if (freeze) begin
            wpcir = 1'b0;
        end else if (ld_stall || br_stall) begin
            wpcir     = 1'b0;
            id_bubble = 1'b1;
        end else if (pcsource != 2'b00) begin
            if_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
module tb_pipeline_interlock_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 5;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             clr;
    logic [4:0]       id_rs, id_rt, ex_rn, mem_rn;
    logic             id_use_rs, id_use_rt, id_branch;
    logic [1:0]       pcsource;
    logic             ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, mem_req, mem_ack;
    logic [1:0]       fwda, fwdb;
    logic             wpcir, id_bubble, if_flush, freeze, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    int vectors     = 0;
    int miscompares = 0;

    pipeline_interlock_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .pcsource(pcsource),
        .ex_rn(ex_rn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .id_bubble(id_bubble),
        .if_flush(if_flush), .freeze(freeze), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_waiting: a memory access is outstanding past its first cycle.
    // m_waits: consecutive frozen cycles so far.
    logic m_waiting;
    int   m_waits, m_stall;
    logic m_to;
    int   e_fwda, e_fwdb;
    logic e_wpcir, e_bub, e_flush, e_freeze;

    function automatic int src_of(input logic [4:0] r);
        if (r == 0) return 0;
        if (ex_wreg && !ex_m2reg && ex_rn == r) return 1;
        if (mem_wreg && mem_rn == r) return mem_m2reg ? 3 : 2;
        return 0;
    endfunction

    always @* begin
        logic hazard;
        e_fwda   = src_of(id_rs);
        e_fwdb   = src_of(id_rt);
        e_freeze = !mem_ack && (m_waiting || mem_req);
        hazard   = ex_wreg && ex_rn != 0 &&
                   ((ex_m2reg && ((id_use_rs && ex_rn == id_rs) || (id_use_rt && ex_rn == id_rt))) ||
                    (id_branch && (ex_rn == id_rs || ex_rn == id_rt)));
        e_wpcir  = !(e_freeze || hazard);
        e_bub    = !e_freeze && hazard;
        e_flush  = e_wpcir && pcsource != 0;
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_waiting <= 1'b0;
            m_waits   <= 0;
            m_to      <= 1'b0;
            m_stall   <= 0;
        end else begin
            int nw;
            nw = e_freeze ? ((m_waits + 1 > MAX_WAIT) ? MAX_WAIT : m_waits + 1) : 0;
            m_waiting <= e_freeze;
            m_waits   <= nw;
            if (e_freeze && nw == MAX_WAIT) m_to <= 1'b1;
            if (!e_wpcir && m_stall < CMAX) m_stall <= m_stall + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!clr) begin
            chk("m_fwda",   32'(fwda),         32'(e_fwda));
            chk("m_fwdb",   32'(fwdb),         32'(e_fwdb));
            chk("m_wpcir",  32'(wpcir),        32'(e_wpcir));
            chk("m_bubble", 32'(id_bubble),    32'(e_bub));
            chk("m_flush",  32'(if_flush),     32'(e_flush));
            chk("m_freeze", 32'(freeze),       32'(e_freeze));
            chk("m_tmo",    32'(mem_timeout),  32'(m_to));
            chk("m_stall",  32'(stall_cycles), 32'(m_stall));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_branch = 0; pcsource = 0;
        ex_rn = 0; ex_wreg = 0; ex_m2reg = 0;
        mem_rn = 0; mem_wreg = 0; mem_m2reg = 0; mem_req = 0; mem_ack = 0;
    endtask

    initial begin
        clr = 1'b1;
        idle();
        #1;
        chk("rst_stall",  32'(stall_cycles), 0);
        chk("rst_tmo",    32'(mem_timeout),  0);
        chk("rst_freeze", 32'(freeze),       0);
        chk("rst_wpcir",  32'(wpcir),        1);
        step(); step();
        clr = 1'b0;
        step();

        // Load-use: lw r3 in EX, consumer reads r3.
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 3; id_rs = 3; id_use_rs = 1;
        #2;
        chk("ld_wpcir",  32'(wpcir),     0);
        chk("ld_bubble", 32'(id_bubble), 1);
        step();
        ex_wreg = 0; ex_m2reg = 0; ex_rn = 0; mem_wreg = 1; mem_m2reg = 1; mem_rn = 3;
        #2;
        chk("ld_fwda",  32'(fwda),         3);
        chk("ld_wpcir2",32'(wpcir),        1);
        chk("ld_stall", 32'(stall_cycles), 1);
        step();

        // Forwarding priority and r0.
        idle();
        ex_wreg = 1; ex_rn = 5; mem_wreg = 1; mem_rn = 5; id_rt = 5;
        #2;
        chk("fw_ex_prio", 32'(fwdb), 1);
        chk("fw_r0_a",    32'(fwda), 0);
        ex_wreg = 0;
        #2;
        chk("fw_mem_alu", 32'(fwdb), 2);
        step();
        ex_wreg = 1; ex_rn = 0; mem_rn = 0; id_rs = 0;
        #2;
        chk("fw_r0_ex", 32'(fwda), 0);
        // load in EX but consumer does not use the register: no stall
        ex_rn = 7; ex_m2reg = 1; id_rs = 7; id_use_rs = 0;
        #2;
        chk("ld_nouse", 32'(wpcir), 1);
        step();

        // Branch redirect, then stalled branch.
        idle();
        id_branch = 1; pcsource = 2'b01; id_rs = 4; id_rt = 6;
        #2;
        chk("br_flush", 32'(if_flush), 1);
        chk("br_wpcir", 32'(wpcir),    1);
        ex_wreg = 1; ex_rn = 4;
        #2;
        chk("brs_wpcir",  32'(wpcir),     0);
        chk("brs_bubble", 32'(id_bubble), 1);
        chk("brs_flush",  32'(if_flush),  0);
        step();
        chk("brs_stall", 32'(stall_cycles), 2);

        // Memory wait of 3 cycles then ack.
        idle();
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mw_freeze", 32'(freeze), 1);
            step();
        end
        mem_ack = 1;
        #2;
        chk("mw_ackfrz", 32'(freeze), 0);
        chk("mw_ackpc",  32'(wpcir),  1);
        step();
        idle();
        #2;
        chk("mw_stall", 32'(stall_cycles), 5);
        chk("mw_tmo",   32'(mem_timeout),  0);
        step();

        // Timeout: 6 wait cycles with MAX_WAIT=4.
        mem_req = 1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("to_flag", 32'(mem_timeout), (i >= 4) ? 1 : 0);
        end
        mem_ack = 1;
        step();
        idle();
        #2;
        chk("to_sticky", 32'(mem_timeout),  1);
        chk("to_stall",  32'(stall_cycles), 11);
        step();

        // Reset mid-wait.
        mem_req = 1;
        step(); step();
        clr = 1'b1; mem_req = 0;
        #1;
        chk("clr_freeze", 32'(freeze),       0);
        chk("clr_tmo",    32'(mem_timeout),  0);
        chk("clr_stall",  32'(stall_cycles), 0);
        step();
        clr = 1'b0;
        step();

        // Long load-use stall saturates the counter.
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 9; id_rt = 9; id_use_rt = 1;
        for (int i = 0; i < 40; i++) step();
        chk("sat_stall", 32'(stall_cycles), 32'(CMAX));
        // Freeze overrides interlock and redirect.
        pcsource = 2'b10; mem_req = 1;
        #2;
        chk("frz_bubble", 32'(id_bubble), 0);
        chk("frz_flush",  32'(if_flush),  0);
        step();
        idle();
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
